// File: rtl/spart_pkg.sv
// Shared definitions for the spart IO bus: register addresses, driver
// state encoding and the default baud divisors for a 100 MHz clock.
package spart_pkg;

  // ioaddr decode of the spart register file
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Divisors for 4800/9600/19200/38400 baud at 100 MHz
  localparam logic [15:0] DIV_4800  = 16'd1302;
  localparam logic [15:0] DIV_9600  = 16'd651;
  localparam logic [15:0] DIV_19200 = 16'd326;
  localparam logic [15:0] DIV_38400 = 16'd163;

  typedef enum logic [2:0] {
    DB_LO,
    DB_HI,
    POLL_RX,
    RD_RX,
    WAIT_TX,
    WR_TX
  } drv_state_e;

endpackage

// File: rtl/spart_driver_sync2.sv
// Generic two-flop synchroniser for slow, quasi-static inputs such as
// DIP switches. Multi-bit use is only safe because the inputs change rarely
// and a transient mixed code is simply re-evaluated on the next poll.
module sync2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Shift the asynchronous input through two flops
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spart_driver.sv
// Bus master standing in for a CPU next to spart: programs the baud divisor
// from the switch setting, then echoes every received byte back out.
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_0 = DIV_4800,
  parameter logic [15:0] DIV_1 = DIV_9600,
  parameter logic [15:0] DIV_2 = DIV_19200,
  parameter logic [15:0] DIV_3 = DIV_38400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] last_rx,
  output logic [7:0] rx_count,
  output logic       cfg_done
);

  function automatic logic [15:0] div_sel(input logic [1:0] cfg);
    case (cfg)
      2'b00:   div_sel = DIV_0;
      2'b01:   div_sel = DIV_1;
      2'b10:   div_sel = DIV_2;
      default: div_sel = DIV_3;
    endcase
  endfunction

  logic [1:0]  cfg_s;
  drv_state_e  state_d, state_q;
  logic        run_d, run_q;
  logic [1:0]  cfg_cur_d, cfg_cur_q;
  logic        cfg_done_d, cfg_done_q;
  logic        iocs_d, iocs_q;
  logic        iorw_d, iorw_q;
  logic [1:0]  ioaddr_d, ioaddr_q;
  logic [7:0]  dout_d, dout_q;
  logic [7:0]  last_rx_d, last_rx_q;
  logic [7:0]  rx_count_d, rx_count_q;
  logic [15:0] div_cur;

  sync2 #(.WIDTH(2)) u_cfg_sync (
    .clk (clk),
    .rst (rst),
    .d   (br_cfg),
    .q   (cfg_s)
  );

  // Next state plus bus outputs for the state being entered, so every bus
  // signal comes straight from a flop. run_q holds off the first access by
  // one cycle so that the bus stays idle throughout reset.
  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    cfg_cur_d  = cfg_cur_q;
    cfg_done_d = cfg_done_q;
    last_rx_d  = last_rx_q;
    rx_count_d = rx_count_q;
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = ADDR_BUF;
    dout_d     = dout_q;

    if (run_q) begin
      case (state_q)
        DB_LO:   state_d = DB_HI;
        DB_HI: begin
          state_d    = POLL_RX;
          cfg_done_d = 1'b1;
        end
        POLL_RX: begin
          // A switch change wins over pending receive data
          if (cfg_s != cfg_cur_q) begin
            state_d    = DB_LO;
            cfg_done_d = 1'b0;
          end else if (rda) begin
            state_d = RD_RX;
          end
        end
        RD_RX: begin
          last_rx_d = databus;
          state_d   = WAIT_TX;
        end
        WAIT_TX: if (tbr) state_d = WR_TX;
        WR_TX: begin
          rx_count_d = rx_count_q + 8'd1;
          state_d    = POLL_RX;
        end
        default: state_d = DB_LO;
      endcase
    end

    // DB_LO never repeats back-to-back, so this fires only on entry
    if (state_d == DB_LO) cfg_cur_d = cfg_s;
    div_cur = div_sel(cfg_cur_d);

    case (state_d)
      DB_LO: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DBL;
        dout_d   = div_cur[7:0];
      end
      DB_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DBH;
        dout_d   = div_cur[15:8];
      end
      RD_RX: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b1;
        ioaddr_d = ADDR_BUF;
      end
      WR_TX: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_BUF;
        dout_d   = last_rx_d;
      end
      default: ;
    endcase
  end

  // Control and visible state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DB_LO;
      run_q      <= 1'b0;
      cfg_cur_q  <= 2'b00;
      cfg_done_q <= 1'b0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= ADDR_BUF;
      last_rx_q  <= 8'h00;
      rx_count_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      cfg_cur_q  <= cfg_cur_d;
      cfg_done_q <= cfg_done_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      last_rx_q  <= last_rx_d;
      rx_count_q <= rx_count_d;
    end
  end

  // Write data register; only observable while the write strobe is up
  always_ff @(posedge clk) begin
    dout_q <= dout_d;
  end

  assign databus  = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign last_rx  = last_rx_q;
  assign rx_count = rx_count_q;
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: a small bus model returns rx_byte on reads,
// expected values are hand-computed divisor bytes and echo results.
module tb_spart_driver;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] last_rx;
  logic [7:0] rx_count;
  logic       cfg_done;
  logic [7:0] rx_byte;

  int checks = 0;
  int errors = 0;
  int contention = 0;
  int stat_hits = 0;

  typedef struct {
    logic [7:0] data;
    int         tbr_wait;
    logic [7:0] exp_cnt;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  // spart side of the bus: answers reads from the RX buffer
  assign databus = (iocs && iorw) ? rx_byte : 8'hzz;

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .rda      (rda),
    .tbr      (tbr),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .last_rx  (last_rx),
    .rx_count (rx_count),
    .cfg_done (cfg_done)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (iocs && iorw && databus !== rx_byte) contention++;
      if (iocs && ioaddr == ADDR_STAT) stat_hits++;
      assert (!(iocs && iorw) || databus === rx_byte)
        else $error("bus contention during read");
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_strobe(input logic rd, input logic [1:0] addr, input int max,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (iocs && iorw == rd && ioaddr == addr) ok = 1'b1;
    end
  endtask

  // One full echo starting from POLL_RX; tbr_wait=0 raises tbr together with rda
  task automatic echo(input logic [7:0] b, input int tbr_wait, input logic [7:0] exp_cnt,
                      input string tag);
    bit ok;
    int busy;
    rx_byte = b;
    rda = 1'b1;
    tbr = (tbr_wait == 0);
    wait_strobe(1'b1, ADDR_BUF, 10, ok);
    chk({tag, "_rd_seen"}, 32'(ok), 32'd1);
    rda = 1'b0;
    if (tbr_wait > 0) begin
      busy = 0;
      repeat (tbr_wait) begin
        @(negedge clk);
        if (iocs) busy++;
      end
      chk({tag, "_wait_idle"}, 32'(busy), 32'd0);
      tbr = 1'b1;
    end
    wait_strobe(1'b0, ADDR_BUF, 10, ok);
    chk({tag, "_wr_seen"}, 32'(ok), 32'd1);
    chk({tag, "_wr_data"}, 32'(databus), 32'(b));
    chk({tag, "_last_rx"}, 32'(last_rx), 32'(b));
    tbr = 1'b0;
    @(negedge clk);
    chk({tag, "_count"}, 32'(rx_count), 32'(exp_cnt));
  endtask

  initial begin
    bit ok;
    int busy;
    int lowcnt;
    int guard;
    logic [7:0] lo_byte;
    logic [7:0] hi_byte;

    rst = 1'b1;
    br_cfg = 2'b00;
    rda = 1'b0;
    tbr = 1'b0;
    rx_byte = 8'h00;
    vecs[0] = '{8'h41, 0, 8'd1};
    vecs[1] = '{8'hC3, 2, 8'd2};
    vecs[2] = '{8'h00, 0, 8'd3};
    vecs[3] = '{8'h7E, 1, 8'd4};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_iocs", 32'(iocs), 32'd0);
    chk("rst_iorw", 32'(iorw), 32'd1);
    chk("rst_ioaddr", 32'(ioaddr), 32'd0);
    chk("rst_last_rx", 32'(last_rx), 32'd0);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_cfg_done", 32'(cfg_done), 32'd0);
    rst = 1'b0;

    // Bring-up with br_cfg=00: 1302 = 0x0516
    @(negedge clk);
    chk("cfg0_lo_iocs", 32'(iocs), 32'd1);
    chk("cfg0_lo_iorw", 32'(iorw), 32'd0);
    chk("cfg0_lo_addr", 32'(ioaddr), 32'(ADDR_DBL));
    chk("cfg0_lo_data", 32'(databus), 32'h16);
    chk("cfg0_lo_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    chk("cfg0_hi_addr", 32'(ioaddr), 32'(ADDR_DBH));
    chk("cfg0_hi_data", 32'(databus), 32'h05);
    @(negedge clk);
    chk("cfg0_idle_iocs", 32'(iocs), 32'd0);
    chk("cfg0_done", 32'(cfg_done), 32'd1);

    // Switch to br_cfg=01: 651 = 0x028B
    br_cfg = 2'b01;
    wait_strobe(1'b0, ADDR_DBL, 10, ok);
    chk("cfg1_lo_seen", 32'(ok), 32'd1);
    chk("cfg1_lo_data", 32'(databus), 32'h8B);
    chk("cfg1_lo_done", 32'(cfg_done), 32'd0);
    @(negedge clk);
    chk("cfg1_hi_addr", 32'(ioaddr), 32'(ADDR_DBH));
    chk("cfg1_hi_data", 32'(databus), 32'h02);
    @(negedge clk);
    chk("cfg1_done", 32'(cfg_done), 32'd1);

    // Table of echoes
    for (int i = 0; i < 4; i++) begin
      echo(vecs[i].data, vecs[i].tbr_wait, vecs[i].exp_cnt, $sformatf("vec%0d", i));
    end

    // tbr held low for 20 cycles in WAIT_TX, then write exactly one cycle after tbr
    rx_byte = 8'h99;
    rda = 1'b1;
    tbr = 1'b0;
    wait_strobe(1'b1, ADDR_BUF, 10, ok);
    chk("hold_rd_seen", 32'(ok), 32'd1);
    rda = 1'b0;
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (iocs || !iorw) busy++;
    end
    chk("hold_idle", 32'(busy), 32'd0);
    tbr = 1'b1;
    wait_strobe(1'b0, ADDR_BUF, 1, ok);
    chk("hold_wr_next_cycle", 32'(ok), 32'd1);
    chk("hold_wr_data", 32'(databus), 32'h99);
    tbr = 1'b0;
    @(negedge clk);
    chk("hold_count", 32'(rx_count), 32'd5);

    // br_cfg change while in WAIT_TX: echo completes, then 163 = 0x00A3
    rx_byte = 8'h5A;
    rda = 1'b1;
    wait_strobe(1'b1, ADDR_BUF, 10, ok);
    chk("chg_rd_seen", 32'(ok), 32'd1);
    rda = 1'b0;
    br_cfg = 2'b11;
    repeat (4) @(negedge clk);
    chk("chg_still_waiting", 32'(iocs), 32'd0);
    tbr = 1'b1;
    wait_strobe(1'b0, ADDR_BUF, 1, ok);
    chk("chg_wr_seen", 32'(ok), 32'd1);
    chk("chg_wr_data", 32'(databus), 32'h5A);
    tbr = 1'b0;
    lowcnt = 0;
    guard = 0;
    lo_byte = 8'hEE;
    hi_byte = 8'hEE;
    while (guard < 12 && !(lowcnt > 0 && cfg_done)) begin
      @(negedge clk);
      guard++;
      if (!cfg_done) lowcnt++;
      if (iocs && !iorw && ioaddr == ADDR_DBL) lo_byte = databus;
      if (iocs && !iorw && ioaddr == ADDR_DBH) hi_byte = databus;
    end
    chk("chg_done_low_cycles", 32'(lowcnt), 32'd2);
    chk("chg_lo_data", 32'(lo_byte), 32'hA3);
    chk("chg_hi_data", 32'(hi_byte), 32'h00);
    chk("chg_count", 32'(rx_count), 32'd6);

    // Reset during the WR_TX cycle; switches back to 00 at the same time
    rx_byte = 8'h77;
    rda = 1'b1;
    tbr = 1'b1;
    wait_strobe(1'b1, ADDR_BUF, 10, ok);
    rda = 1'b0;
    wait_strobe(1'b0, ADDR_BUF, 10, ok);
    chk("mid_wr_seen", 32'(ok), 32'd1);
    rst = 1'b1;
    br_cfg = 2'b00;
    tbr = 1'b0;
    @(negedge clk);
    chk("mid_rst_iocs", 32'(iocs), 32'd0);
    chk("mid_rst_iorw", 32'(iorw), 32'd1);
    chk("mid_rst_drive", 32'(iocs && !iorw), 32'd0);
    chk("mid_rst_count", 32'(rx_count), 32'd0);
    chk("mid_rst_last_rx", 32'(last_rx), 32'd0);
    chk("mid_rst_done", 32'(cfg_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_re_lo_addr", 32'(ioaddr), 32'(ADDR_DBL));
    chk("mid_re_lo_iocs", 32'(iocs), 32'd1);
    chk("mid_re_lo_data", 32'(databus), 32'h16);
    repeat (2) @(negedge clk);
    chk("mid_re_done", 32'(cfg_done), 32'd1);

    // 256 echoes of 0x00..0xFF: count wraps back to zero
    for (int i = 0; i < 256; i++) begin
      echo(8'(i), 0, 8'(i + 1), "wrap");
    end
    chk("wrap_count", 32'(rx_count), 32'd0);
    chk("wrap_last_rx", 32'(last_rx), 32'hFF);
    chk("no_contention", 32'(contention), 32'd0);
    chk("no_status_access", 32'(stat_hits), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
